// File: rtl/regfile_bypass_sb_pkg.sv
// Shared types and defaults for the bypassing register file
// and its scoreboard.
package regfile_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

    typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
    typedef logic [DEF_DATA_W-1:0] reg_word_t;

    localparam int ZERO_IDX = 0;

endpackage

// File: rtl/regfile_bypass_sb_if.sv
// Decode/writeback bundle for the register file: read ports,
// two write ports, reservation request and scoreboard status.
interface regfile_bypass_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;

    logic              wa_en;
    logic [ADDR_W-1:0] wa_addr;
    logic [DATA_W-1:0] wa_data;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              rsv_ack;
    logic              any_busy;

    modport master (
        output rd_addr1, rd_addr2,
        output wa_en, wa_addr, wa_data,
        output wb_en, wb_addr, wb_data,
        output rsv_en, rsv_addr,
        input  rd_data1, rd_data2,
        input  rd_busy1, rd_busy2,
        input  rsv_ack, any_busy
    );

    modport slave (
        input  rd_addr1, rd_addr2,
        input  wa_en, wa_addr, wa_data,
        input  wb_en, wb_addr, wb_data,
        input  rsv_en, rsv_addr,
        output rd_data1, rd_data2,
        output rd_busy1, rd_busy2,
        output rsv_ack, any_busy
    );

endinterface

// File: rtl/regfile_bypass_sb_read_port.sv
// One combinational read port: zero-register override, same-cycle
// write bypass (port B over port A) and scoreboard busy select.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                             rst_i,
    input  logic [ADDR_W-1:0]                addr_i,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_i,
    input  logic [NUM_REGS-1:0]              busy_i,
    input  logic                             wa_en_i,
    input  logic [ADDR_W-1:0]                wa_addr_i,
    input  logic [DATA_W-1:0]                wa_data_i,
    input  logic                             wb_en_i,
    input  logic [ADDR_W-1:0]                wb_addr_i,
    input  logic [DATA_W-1:0]                wb_data_i,
    output logic [DATA_W-1:0]                data_o,
    output logic                             busy_o
);

    logic hit_a;
    logic hit_b;
    logic is_zero;

    always_comb begin
        hit_a   = (BYPASS != 0) && wa_en_i && (wa_addr_i == addr_i);
        hit_b   = (BYPASS != 0) && wb_en_i && (wb_addr_i == addr_i);
        is_zero = (ZERO_REG != 0) && (addr_i == ADDR_W'(ZERO_IDX));

        // Bypass would otherwise leak write data while reset holds.
        if (rst_i || is_zero) begin
            data_o = '0;
        end else if (hit_b) begin
            data_o = wb_data_i;
        end else if (hit_a) begin
            data_o = wa_data_i;
        end else begin
            data_o = regs_i[addr_i];
        end

        // A bypassed write is consumable now, so it is not busy.
        if (rst_i || hit_a || hit_b) begin
            busy_o = 1'b0;
        end else begin
            busy_o = busy_i[addr_i];
        end
    end

endmodule

// File: rtl/regfile_bypass_sb.sv
// Two-read, two-write register file with write bypass and a
// per-register busy scoreboard for issue stalls.
module regfile_bypass_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst,
    regfile_bypass_sb_if.slave  rf
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             busy_q, busy_d;
    logic                            ack_q, ack_d;

    logic rsv_ok;
    logic rsv_zero;
    logic wa_ok;
    logic wb_ok;

    always_comb begin
        regs_d   = regs_q;
        busy_d   = busy_q;
        rsv_zero = (ZERO_REG != 0) && (rf.rsv_addr == ADDR_W'(ZERO_IDX));
        wa_ok    = rf.wa_en &&
                   !((ZERO_REG != 0) && (rf.wa_addr == ADDR_W'(ZERO_IDX)));
        wb_ok    = rf.wb_en &&
                   !((ZERO_REG != 0) && (rf.wb_addr == ADDR_W'(ZERO_IDX)));
        rsv_ok   = rf.rsv_en && !busy_q[rf.rsv_addr];
        ack_d    = rsv_ok;

        if (rsv_ok && !rsv_zero) begin
            busy_d[rf.rsv_addr] = 1'b1;
        end
        // Writes come after the set so a same-index clear wins,
        // and port B after port A so B wins an address collision.
        if (wa_ok) begin
            regs_d[rf.wa_addr] = rf.wa_data;
            busy_d[rf.wa_addr] = 1'b0;
        end
        if (wb_ok) begin
            regs_d[rf.wb_addr] = rf.wb_data;
            busy_d[rf.wb_addr] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
            ack_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            ack_q  <= ack_d;
        end
    end

    assign rf.rsv_ack  = ack_q;
    assign rf.any_busy = |busy_q;

    rf_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_rp1 (
        .rst_i     (rst),
        .addr_i    (rf.rd_addr1),
        .regs_i    (regs_q),
        .busy_i    (busy_q),
        .wa_en_i   (rf.wa_en),
        .wa_addr_i (rf.wa_addr),
        .wa_data_i (rf.wa_data),
        .wb_en_i   (rf.wb_en),
        .wb_addr_i (rf.wb_addr),
        .wb_data_i (rf.wb_data),
        .data_o    (rf.rd_data1),
        .busy_o    (rf.rd_busy1)
    );

    rf_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_rp2 (
        .rst_i     (rst),
        .addr_i    (rf.rd_addr2),
        .regs_i    (regs_q),
        .busy_i    (busy_q),
        .wa_en_i   (rf.wa_en),
        .wa_addr_i (rf.wa_addr),
        .wa_data_i (rf.wa_data),
        .wb_en_i   (rf.wb_en),
        .wb_addr_i (rf.wb_addr),
        .wb_data_i (rf.wb_data),
        .data_o    (rf.rd_data2),
        .busy_o    (rf.rd_busy2)
    );

endmodule
